// File: rtl/hwpe_stream_package.sv
// Shared types for the HWPE-Stream TCDM reader: control/flag records and the FSM state encoding.
package hwpe_stream_package;

    localparam int unsigned TcdmReaderAddrW = 32;
    localparam int unsigned TcdmReaderDataW = 32;
    localparam int unsigned TcdmReaderCntW  = 16;

    typedef struct packed {
        logic [TcdmReaderAddrW-1:0] base_addr;
        logic [TcdmReaderAddrW-1:0] stride;
        logic [TcdmReaderCntW-1:0]  words;
    } ctrl_tcdm_reader_t;

    typedef struct packed {
        logic busy;
        logic done;
    } flags_tcdm_reader_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } tcdm_reader_state_t;

endpackage

// File: rtl/hwpe_stream_addressgen_1d.sv
// 1-D address generator: latches base/stride/length, steps the address per granted request
// and flags the request that completes the transfer.
module hwpe_stream_addressgen_1d #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic                  advance_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH-1:0] stride_i,
    input  logic [CNT_WIDTH-1:0]  words_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [CNT_WIDTH-1:0]  words_o,
    output logic [CNT_WIDTH-1:0]  req_cnt_o,
    output logic                  last_o
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d, stride_q, stride_d;
    logic [CNT_WIDTH-1:0]  words_q, words_d, cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  cnt_inc;

    assign cnt_inc = cnt_q + CNT_WIDTH'(1);

    always_comb begin
        addr_d   = addr_q;
        stride_d = stride_q;
        words_d  = words_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            addr_d   = '0;
            stride_d = '0;
            words_d  = '0;
            cnt_d    = '0;
        end else if (load_i) begin
            addr_d   = base_addr_i;
            stride_d = stride_i;
            words_d  = words_i;
            cnt_d    = '0;
        end else if (advance_i) begin
            // Two's-complement stride: plain modular add covers negative steps and wrap.
            addr_d = addr_q + stride_q;
            cnt_d  = cnt_inc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q   <= '0;
            stride_q <= '0;
            words_q  <= '0;
            cnt_q    <= '0;
        end else begin
            addr_q   <= addr_d;
            stride_q <= stride_d;
            words_q  <= words_d;
            cnt_q    <= cnt_d;
        end
    end

    assign addr_o    = addr_q;
    assign words_o   = words_q;
    assign req_cnt_o = cnt_q;
    assign last_o    = advance_i && (cnt_inc == words_q);

endmodule

// File: rtl/hwpe_stream_tcdm_reader.sv
// Strided TCDM read engine: issues a run of loads, forwards responses as a HWPE-Stream
// and pulses done once every response has been streamed out.
module hwpe_stream_tcdm_reader
    import hwpe_stream_package::*;
#(
    parameter int unsigned ADDR_WIDTH = TcdmReaderAddrW,
    parameter int unsigned DATA_WIDTH = TcdmReaderDataW,
    parameter int unsigned CNT_WIDTH  = TcdmReaderCntW
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [ADDR_WIDTH-1:0]   stride_i,
    input  logic [CNT_WIDTH-1:0]    words_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    tcdm_req_o,
    input  logic                    tcdm_gnt_i,
    output logic [ADDR_WIDTH-1:0]   tcdm_add_o,
    output logic                    tcdm_wen_o,
    output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
    output logic [DATA_WIDTH-1:0]   tcdm_data_o,
    input  logic                    tcdm_r_valid_i,
    input  logic [DATA_WIDTH-1:0]   tcdm_r_data_i,
    output logic                    tcdm_fifo_ready_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [DATA_WIDTH-1:0]   out_data_o,
    output logic [DATA_WIDTH/8-1:0] out_strb_o
);

    tcdm_reader_state_t state_q;
    flags_tcdm_reader_t flags_q;
    logic [CNT_WIDTH-1:0] rsp_cnt_q, rsp_cnt_inc, req_cnt, words_q;
    logic load, advance, last;

    assign load        = (state_q == StIdle) && start_i && !clear_i;
    assign advance     = (state_q == StIssue) && tcdm_gnt_i && !clear_i;
    assign rsp_cnt_inc = rsp_cnt_q + CNT_WIDTH'(tcdm_r_valid_i);

    hwpe_stream_addressgen_1d #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_addressgen (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .load_i      (load),
        .advance_i   (advance),
        .base_addr_i (base_addr_i),
        .stride_i    (stride_i),
        .words_i     (words_i),
        .addr_o      (tcdm_add_o),
        .words_o     (words_q),
        .req_cnt_o   (req_cnt),
        .last_o      (last)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            rsp_cnt_q <= '0;
            flags_q   <= '0;
        end else if (clear_i) begin
            state_q   <= StIdle;
            rsp_cnt_q <= '0;
            flags_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        rsp_cnt_q <= '0;
                        if (words_i == '0) begin
                            state_q <= StDone;
                            flags_q <= '{busy: 1'b0, done: 1'b1};
                        end else begin
                            state_q <= StIssue;
                            flags_q <= '{busy: 1'b1, done: 1'b0};
                        end
                    end
                end
                StIssue: begin
                    rsp_cnt_q <= rsp_cnt_inc;
                    if (last) state_q <= StWait;
                end
                StWait: begin
                    rsp_cnt_q <= rsp_cnt_inc;
                    if (rsp_cnt_inc == words_q) begin
                        state_q <= StDone;
                        flags_q <= '{busy: 1'b0, done: 1'b1};
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    flags_q <= '0;
                end
                default: begin
                    state_q <= StIdle;
                    flags_q <= '0;
                end
            endcase
        end
    end

    assign busy_o      = flags_q.busy;
    assign done_o      = flags_q.done;
    assign tcdm_req_o  = (state_q == StIssue);
    assign tcdm_wen_o  = 1'b1;
    assign tcdm_be_o   = '1;
    assign tcdm_data_o = '0;

    // The upstream FIFO only presents a response while ready is high, so no buffering here.
    assign tcdm_fifo_ready_o = out_ready_i;
    assign out_valid_o       = tcdm_r_valid_i;
    assign out_data_o        = tcdm_r_data_i;
    assign out_strb_o        = '1;

`ifndef SYNTHESIS
    rsp_outside_transfer: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(tcdm_r_valid_i && ((state_q == StIdle) || (state_q == StDone))));
    outstanding_nonneg: assert property (@(posedge clk_i) disable iff (!rst_ni)
        req_cnt >= rsp_cnt_q);
`endif

endmodule
